// File: rtl/mandelbrot_iter_ctrl_if.sv
// Point/result handshakes and the external step-ALU wiring for mandelbrot_iter_ctrl.
// The slave modport is the controller's view; master is the scan/colour/ALU side.
interface mandelbrot_iter_ctrl_if #(
  parameter int WIDTH      = 8,
  parameter int ITER_WIDTH = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_cr;
  logic [WIDTH-1:0]       in_ci;
  logic [ITER_WIDTH-1:0]  in_max_iter;

  logic [WIDTH-1:0]       alu_cr;
  logic [WIDTH-1:0]       alu_ci;
  logic [WIDTH-1:0]       alu_zr;
  logic [WIDTH-1:0]       alu_zi;
  logic [WIDTH-1:0]       alu_out_zr;
  logic [WIDTH-1:0]       alu_out_zi;
  logic                   alu_size;
  logic                   alu_overflow;

  logic                   out_valid;
  logic                   out_ready;
  logic [ITER_WIDTH-1:0]  out_count;
  logic                   out_escaped;

  modport slave (
    input  in_valid, in_cr, in_ci, in_max_iter,
    output in_ready,
    output alu_cr, alu_ci, alu_zr, alu_zi,
    input  alu_out_zr, alu_out_zi, alu_size, alu_overflow,
    output out_valid, out_count, out_escaped,
    input  out_ready
  );

  modport master (
    output in_valid, in_cr, in_ci, in_max_iter,
    input  in_ready,
    input  alu_cr, alu_ci, alu_zr, alu_zi,
    output alu_out_zr, alu_out_zi, alu_size, alu_overflow,
    input  out_valid, out_count, out_escaped,
    output out_ready
  );
endinterface

// File: rtl/mandelbrot_iter_ctrl.sv
// Per-pixel Mandelbrot iteration sequencer: holds c and z, steps the external ALU
// once per clock until escape or the iteration limit, then offers count/escape flag.
module mandelbrot_iter_ctrl #(
  parameter int WIDTH      = 8,
  parameter int ITER_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  mandelbrot_iter_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state, state_nxt;
  logic [WIDTH-1:0]       cr, ci, zr, zi;
  logic [WIDTH-1:0]       cr_nxt, ci_nxt, zr_nxt, zi_nxt;
  logic [ITER_WIDTH-1:0]  max_iter, max_iter_nxt;
  logic [ITER_WIDTH-1:0]  count, count_nxt, count_inc;
  logic                   escaped, escaped_nxt;

  assign count_inc = count + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cr       <= '0;
      ci       <= '0;
      zr       <= '0;
      zi       <= '0;
      max_iter <= '0;
      count    <= '0;
      escaped  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cr       <= cr_nxt;
      ci       <= ci_nxt;
      zr       <= zr_nxt;
      zi       <= zi_nxt;
      max_iter <= max_iter_nxt;
      count    <= count_nxt;
      escaped  <= escaped_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cr_nxt       = cr;
    ci_nxt       = ci;
    zr_nxt       = zr;
    zi_nxt       = zi;
    max_iter_nxt = max_iter;
    count_nxt    = count;
    escaped_nxt  = escaped;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          cr_nxt       = bus.in_cr;
          ci_nxt       = bus.in_ci;
          max_iter_nxt = bus.in_max_iter;
          zr_nxt       = '0;
          zi_nxt       = '0;
          count_nxt    = '0;
          escaped_nxt  = 1'b0;
          state_nxt    = (bus.in_max_iter == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // Escape takes priority over reaching the limit on the same edge.
        if (bus.alu_size || bus.alu_overflow) begin
          escaped_nxt = 1'b1;
          state_nxt   = DONE;
        end else begin
          zr_nxt    = bus.alu_out_zr;
          zi_nxt    = bus.alu_out_zi;
          count_nxt = count_inc;
          if (count_inc == max_iter) begin
            escaped_nxt = 1'b0;
            state_nxt   = DONE;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = (state == DONE);
  assign bus.out_count   = count;
  assign bus.out_escaped = escaped;
  assign bus.alu_cr      = cr;
  assign bus.alu_ci      = ci;
  assign bus.alu_zr      = zr;
  assign bus.alu_zi      = zi;

endmodule

// File: tb/tb_mandelbrot_iter_ctrl.sv
// Directed bench for mandelbrot_iter_ctrl with a behavioural 2.6 fixed-point step ALU.
module tb_mandelbrot_iter_ctrl;

  logic clk;
  logic rst;

  mandelbrot_iter_ctrl_if #(.WIDTH(8), .ITER_WIDTH(8)) bus ();

  mandelbrot_iter_ctrl #(.WIDTH(8), .ITER_WIDTH(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Step ALU: z' = z^2 + c in signed 2.6, flags on |z|^2 > 4 and unrepresentable z'.
  int ar, ai, acr, aci, nzr, nzi;
  always_comb begin
    ar  = int'($signed(bus.alu_zr));
    ai  = int'($signed(bus.alu_zi));
    acr = int'($signed(bus.alu_cr));
    aci = int'($signed(bus.alu_ci));
    nzr = ((ar * ar - ai * ai) >>> 6) + acr;
    nzi = ((2 * ar * ai) >>> 6) + aci;
    bus.alu_out_zr   = nzr[7:0];
    bus.alu_out_zi   = nzi[7:0];
    bus.alu_size     = (ar * ar + ai * ai) > 16384;
    bus.alu_overflow = (nzr > 127) || (nzr < -128) || (nzi > 127) || (nzi < -128);
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int  cr;
    int  ci;
    int  max_iter;
    int  exp_count;
    int  exp_esc;
    int  exp_lat;   // edges after the accept edge until out_valid is seen
  } vec_t;

  vec_t vecs[8];

  // Offer one point, wait for the result, check it, then take it.
  task automatic run_point(input vec_t v, input string tag);
    int  lat;
    int  nz;
    bit  done;
    @(negedge clk);
    check({tag, ":in_ready"}, int'(bus.in_ready), 1);
    bus.in_valid    = 1'b1;
    bus.in_cr       = v.cr[7:0];
    bus.in_ci       = v.ci[7:0];
    bus.in_max_iter = v.max_iter[7:0];
    @(negedge clk);
    bus.in_valid    = 1'b0;
    bus.in_cr       = 8'h5a;
    bus.in_ci       = 8'ha5;
    bus.in_max_iter = 8'd3;
    lat  = 0;
    nz   = 0;
    done = 1'b0;
    while (!done && lat <= 300) begin
      if (bus.out_valid) done = 1'b1;
      else begin
        if (bus.alu_zr != 8'd0 || bus.alu_zi != 8'd0) nz++;
        if (bus.in_ready) nz += 1000;
        @(negedge clk);
        lat++;
      end
    end
    if (!done) $display("FAIL %s:timeout: got no out_valid, expected one within 300 cycles", tag);
    check({tag, ":latency"}, lat, v.exp_lat);
    check({tag, ":count"}, int'(bus.out_count), v.exp_count);
    check({tag, ":escaped"}, int'(bus.out_escaped), v.exp_esc);
    check({tag, ":alu_cr"}, int'($signed(bus.alu_cr)), v.cr);
    check({tag, ":alu_ci"}, int'($signed(bus.alu_ci)), v.ci);
    if (v.cr == 0 && v.ci == 0) check({tag, ":alu_z_zero_busy"}, nz, 0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, ":released_valid"}, int'(bus.out_valid), 0);
    check({tag, ":released_ready"}, int'(bus.in_ready), 1);
    check({tag, ":count_held"}, int'(bus.out_count), v.exp_count);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //           cr   ci  max  count esc lat
    vecs[0] = '{   0,   0,  20,  20,  0,  20};
    vecs[1] = '{  64,  64, 255,   1,  1,   2};
    vecs[2] = '{ -64,   0, 255, 255,  0, 255};
    vecs[3] = '{  17, -33,   0,   0,  0,   0};
    vecs[4] = '{  64,  64,   1,   1,  0,   1};
    vecs[5] = '{  64,  64,   2,   1,  1,   2};
    vecs[6] = '{-128,-128, 255,   1,  1,   2};
    vecs[7] = '{   0,  64,  30,  30,  0,  30};

    rst             = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in_cr       = '0;
    bus.in_ci       = '0;
    bus.in_max_iter = '0;
    bus.out_ready   = 1'b0;
    @(negedge clk);
    check("rst:in_ready", int'(bus.in_ready), 1);
    check("rst:out_valid", int'(bus.out_valid), 0);
    check("rst:out_count", int'(bus.out_count), 0);
    check("rst:out_escaped", int'(bus.out_escaped), 0);
    check("rst:alu_all", int'({bus.alu_cr, bus.alu_ci, bus.alu_zr, bus.alu_zi}), 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_point(vecs[i], $sformatf("vec%0d", i));

    // Zero limit, result held while the consumer stalls and new offers are ignored.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_cr = 8'd37; bus.in_ci = 8'hec; bus.in_max_iter = 8'd0;
    @(negedge clk);
    check("hold:valid_after_e0", int'(bus.out_valid), 1);
    for (int c = 0; c < 5; c++) begin
      bus.in_valid    = c[0];
      bus.in_cr       = 8'd99;
      bus.in_max_iter = 8'd7;
      @(negedge clk);
      check($sformatf("hold%0d:out_valid", c), int'(bus.out_valid), 1);
      check($sformatf("hold%0d:in_ready", c), int'(bus.in_ready), 0);
      check($sformatf("hold%0d:count", c), int'(bus.out_count), 0);
      check($sformatf("hold%0d:escaped", c), int'(bus.out_escaped), 0);
      check($sformatf("hold%0d:alu_cr", c), int'(bus.alu_cr), 37);
    end
    bus.in_valid = 1'b0;
    // Reset while DONE drops out_valid without a clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst_done:out_valid", int'(bus.out_valid), 0);
    check("rst_done:in_ready", int'(bus.in_ready), 1);
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-run of c=0 after seven iterations, then a clean escaping point.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_cr = 8'd0; bus.in_ci = 8'd0; bus.in_max_iter = 8'd20;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("midrun:count_before", int'(bus.out_count), 7);
    check("midrun:busy", int'(bus.in_ready), 0);
    #2 rst = 1'b1;
    #1;
    check("midrun:in_ready", int'(bus.in_ready), 1);
    check("midrun:out_valid", int'(bus.out_valid), 0);
    check("midrun:count", int'(bus.out_count), 0);
    @(negedge clk);
    rst = 1'b0;
    run_point(vecs[1], "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mandelbrot_iter_ctrl.md
# mandelbrot_iter_ctrl

Per-pixel iteration sequencer for the combinational Mandelbrot step ALU (one z ← z² + c step per evaluation). It accepts a point c with a valid/ready handshake and holds z in registers. It feeds the ALU once per clock until the point escapes or the iteration limit is reached. It then presents the iteration count and escape flag on a valid/ready result port. It sits between the pixel scan generator and the colour/output stage; the ALU is instantiated outside and wired through the `alu_*` ports.

## Interface
- `WIDTH`, 8: data width of cr, ci, zr and zi. Signed fixed point 2.(WIDTH-2), so 1.0 = 64 at WIDTH=8.
- `ITER_WIDTH`, 8: width of the iteration limit and of the count.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  a new point is offered.
- `in_ready`  out  1  controller can accept a point.
- `in_cr`, `in_ci`  in  WIDTH each  c, signed 2.(WIDTH-2).
- `in_max_iter`  in  ITER_WIDTH  iteration limit, unsigned.
- `alu_cr`, `alu_ci`  out  WIDTH each  latched c to the ALU.
- `alu_zr`, `alu_zi`  out  WIDTH each  current z to the ALU.
- `alu_out_zr`, `alu_out_zi`  in  WIDTH each  next z from the ALU.
- `alu_size`  in  1  ALU flag: |z|² > 4 for the current z.
- `alu_overflow`  in  1  ALU flag: next z is not representable.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `out_count`  out  ITER_WIDTH  completed iterations.
- `out_escaped`  out  1  1 = terminated by size or overflow; 0 = terminated by the limit.

## Operation
- States: IDLE, RUN, DONE. Encoding is free.
- Reset (async, asserted): state IDLE and all registers cleared.
  - Outputs in reset: in_ready=1, out_valid=0, out_count=0, out_escaped=0, all alu_* outputs = 0.
- `in_ready` = (state==IDLE). `out_valid` = (state==DONE). Both are decoded directly from registered state.
- IDLE, on an edge where in_valid & in_ready:
  - Latch cr, ci and max_iter; clear z to 0 and count to 0.
  - If in_max_iter==0: go to DONE with count=0, escaped=0.
  - Otherwise: go to RUN.
- RUN, each edge:
  - If alu_size | alu_overflow: go to DONE, escaped=1, count unchanged, z unchanged.
  - Else: z ← (alu_out_zr, alu_out_zi) and count ← count+1. If count+1 == max_iter: go to DONE, escaped=0.
- Count never exceeds max_iter, so it does not wrap. Comparison is unsigned, full ITER_WIDTH.
- DONE, on an edge where out_ready: go to IDLE. out_count and out_escaped hold their values until the next accept.
- While in DONE, out_count, out_escaped and all alu_* outputs are stable.
- in_valid is ignored outside IDLE. There is no skid buffer, so there is no back-to-back accept in the same cycle the result is taken.
- `alu_cr/ci/zr/zi` are driven straight from registers, with no combinational path from any input.
- Simultaneous escape and limit on the same edge: escape wins, escaped=1, count unchanged.
- Reset asserted mid-RUN or in DONE: immediate return to IDLE. The pending result is discarded and out_valid falls asynchronously.

## Timing
- One ALU evaluation per clock.
- Let E0 be the accept edge. A point that completes k iterations and then escapes raises out_valid after edge E(k+1).
- A point that hits the limit N raises out_valid after edge EN.
- Limit N=0: out_valid after E0 + 1 clock (i.e. after E0 itself; state is DONE in the cycle following the accept).
- Result handshake edge: out_valid falls and in_ready rises in the following cycle.
- Minimum period per pixel is k+2 cycles, including 1 IDLE cycle.

## Test plan
- Reset value check: hold rst high mid-cycle → in_ready=1, out_valid=0, out_count=0, out_escaped=0, alu_* = 0.
- c=(0,0), max_iter=20 → out_valid after the 20th edge after accept; count=20, escaped=0; alu_zr/zi stay 0 throughout.
- c=(64,64) [1.0+1.0i], max_iter=255, WIDTH=8:
  - Iteration 1 gives z=(64,64).
  - Iteration 2: ALU overflows (zi=3.0).
  - Result: count=1, escaped=1, out_valid after E2.
- c=(-64,0) [-1.0], max_iter=255:
  - z alternates 0/-64 every cycle.
  - Result: count=255, escaped=0, out_valid after E255.
- max_iter=0, any c → DONE one edge after accept, count=0, escaped=0. Then with out_ready held low 5 cycles → outputs stable, in_ready=0, in_valid pulses ignored.
- Assert rst during RUN of the c=(0,0), max_iter=20 case at iteration 7 → immediate IDLE. A following accept of c=(64,64) must give count=1, escaped=1, with no stale state.
